decoder_scan_nto2n: RTL and testbench
=====================================

Name: decoder_scan_nto2n

Overview:
Parametrised, registered N-to-2^N one-hot decoder with enable, output polarity select and a valid/ready capture handshake. It adds an autonomous scan mode that steps the active output through all 2^N lines, with programmable dwell and optional break-before-make blanking, for row/column strobing of LED matrices and keypads. It sits between a control register block (sel/mode/dwell) and the pad drivers.

Parameters:
SEL_W, 3, select width; output width OUT_W = 2**SEL_W (legal 1..6)
DWELL_W, 8, width of dwell count input
ACTIVE_LOW, 0, 1 = asserted output line is 0, inactive lines are 1
BLANK_EN, 1, 1 = one all-inactive cycle between scan steps

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  block enable; low forces outputs inactive
mode  input  1  0 = direct decode, 1 = scan
in_valid  input  1  sel_in offered (direct mode)
in_ready  output  1  capture possible; = enable & ~mode (combinational)
sel_in  input  SEL_W  line index to assert
dwell  input  DWELL_W  scan step holds dwell+1 cycles
out  output  OUT_W  registered decoded lines (polarity per ACTIVE_LOW)
out_valid  output  1  a line is currently asserted
cur_sel  output  SEL_W  index of asserted/last-asserted line
scan_wrap  output  1  one-cycle pulse when scan index wraps OUT_W-1 -> 0

Behaviour:
- Clock: one clock, clk. Reset: rst_n, asynchronous assert, active-low; all outputs registered except in_ready.
- Reset values: out = all inactive (0s, or all 1s if ACTIVE_LOW), out_valid 0, cur_sel 0, scan_wrap 0, state IDLE, dwell counter 0.
- "Inactive" below means every out bit at its inactive level; asserted line = active level, all others inactive.
- States: IDLE, DIRECT, SCAN_ON, SCAN_BLANK.
- enable = 0 (any state): next edge -> IDLE, out inactive, out_valid 0, counters cleared; in_valid ignored. Highest priority.
- Direct capture: in_valid & in_ready at edge -> next cycle out = one-hot(sel_in), cur_sel = sel_in, out_valid 1, state DIRECT. Latency 1 cycle. Value held until next capture; in_valid without capture changes nothing. Back-to-back captures update every cycle.
- IDLE/DIRECT with enable=1, mode=0, no capture: hold current out (inactive from IDLE).
- Entering scan (mode=1, enable=1, from IDLE or DIRECT): next cycle SCAN_ON, index 0 asserted, out_valid 1, dwell sampled into counter.
- SCAN_ON: asserts line cur_sel for dwell+1 cycles (dwell=0 -> 1 cycle). At end: BLANK_EN=1 -> SCAN_BLANK for exactly 1 cycle (out inactive, out_valid 0, cur_sel unchanged), then SCAN_ON with index+1; BLANK_EN=0 -> directly SCAN_ON with index+1, no gap.
- Index increments modulo OUT_W; on the edge where the index loads 0 after OUT_W-1, scan_wrap = 1 for that cycle only. dwell re-sampled at each SCAN_ON entry; mid-step dwell changes ignored.
- Scan -> direct (mode falls): next cycle DIRECT with out inactive, out_valid 0, until a capture; capture in that same cycle is honoured (in_ready already 1), giving asserted line next cycle.
- Direct -> scan always restarts at index 0.
- Reset mid-operation: immediate return to reset values regardless of state.
- OUT_W=2 (SEL_W=1) must work; scan alternates 0,1 with wrap every second step.

Decomposition:
- Package decoder_pkg: state enum typedef (IDLE, DIRECT, SCAN_ON, SCAN_BLANK), function onehot(sel) returning OUT_W vector, polarity helper.
- One sub-module natural: decoder_onehot (combinational SEL_W-to-2^SEL_W decode with enable and ACTIVE_LOW), instantiated ahead of the output register; FSM, dwell counter and index counter stay in the top.

Test Plan:
- Reset: rst_n=0 mid-scan (async, between edges) -> out=8'h00, out_valid=0, cur_sel=0, scan_wrap=0 immediately.
- Direct: enable=1, mode=0, in_valid=1, sel_in=5 -> next cycle out=8'h20, cur_sel=5; then in_valid=0, sel_in=2 -> out stays 8'h20.
- Scan, dwell=1, BLANK_EN=1: out sequence 01,01,00,02,02,00,04,... ; scan_wrap=1 on the cycle out returns to 01 after 80.
- Scan, dwell=0, BLANK_EN=0: out 01,02,04,...,80,01 one per cycle; scan_wrap pulses once per 8 cycles.
- ACTIVE_LOW=1, direct sel_in=0 -> out=8'hFE; enable=0 -> next cycle out=8'hFF, in_ready=0, in_valid pulses ignored.
- Mode 1->0 mid-step with in_valid=1, sel_in=3 same cycle -> next cycle out=8'h08, state DIRECT; then mode=1 -> restart at out=8'h01.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the scanning N-to-2^N decoder.
package decoder_pkg;

  localparam int unsigned MAX_SEL_W = 6;
  localparam int unsigned MAX_OUT_W = 64;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DIRECT     = 2'd1,
    SCAN_ON    = 2'd2,
    SCAN_BLANK = 2'd3
  } state_e;

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
    logic [MAX_OUT_W-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

  function automatic logic [MAX_OUT_W-1:0] polarity(input logic [MAX_OUT_W-1:0] v,
                                                    input logic active_low);
    return active_low ? ~v : v;
  endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational SEL_W-to-2^SEL_W decode with line enable and output polarity.
module decoder_onehot
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W      = 3,
  parameter bit          ACTIVE_LOW = 1'b0,
  localparam int unsigned OUT_W     = 2 ** SEL_W
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [OUT_W-1:0] lines_c
);

  logic [MAX_OUT_W-1:0] hot;

  always_comb begin
    hot     = en ? onehot(MAX_SEL_W'(sel)) : '0;
    lines_c = OUT_W'(polarity(hot, ACTIVE_LOW));
  end

endmodule

// File: rtl/decoder_scan_nto2n.sv
// Registered one-hot decoder with valid/ready capture and an autonomous line-scan mode.
module decoder_scan_nto2n
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned DWELL_W    = 8,
  parameter bit          ACTIVE_LOW = 1'b0,
  parameter bit          BLANK_EN   = 1'b1,
  localparam int unsigned OUT_W     = 2 ** SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   out,
  output logic               out_valid,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               scan_wrap
);

  state_e               state, state_n;
  logic [DWELL_W-1:0]   cnt, cnt_n;
  logic [SEL_W-1:0]     sel_n;
  logic                 on_n;
  logic                 wrap_n;
  logic                 next_step;
  logic [OUT_W-1:0]     out_d;

  assign in_ready = enable & ~mode;

  // Next-state and next-output selection; disable overrides everything.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sel_n     = cur_sel;
    on_n      = out_valid;
    wrap_n    = 1'b0;
    next_step = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      sel_n   = '0;
      on_n    = 1'b0;
    end else if (!mode) begin
      cnt_n = '0;
      if (in_valid) begin
        state_n = DIRECT;
        sel_n   = sel_in;
        on_n    = 1'b1;
      end else if (state == SCAN_ON || state == SCAN_BLANK) begin
        state_n = DIRECT;
        on_n    = 1'b0;
      end
    end else begin
      unique case (state)
        IDLE, DIRECT: begin
          state_n = SCAN_ON;
          sel_n   = '0;
          on_n    = 1'b1;
          cnt_n   = dwell;
        end
        SCAN_ON: begin
          if (cnt != '0) begin
            cnt_n = cnt - DWELL_W'(1);
          end else if (BLANK_EN) begin
            state_n = SCAN_BLANK;
            on_n    = 1'b0;
          end else begin
            next_step = 1'b1;
          end
        end
        SCAN_BLANK: next_step = 1'b1;
        default:    state_n = IDLE;
      endcase
      // Step to the next line; index wraps naturally since OUT_W = 2^SEL_W.
      if (next_step) begin
        state_n = SCAN_ON;
        sel_n   = cur_sel + SEL_W'(1);
        on_n    = 1'b1;
        cnt_n   = dwell;
        wrap_n  = &cur_sel;
      end
    end
  end

  decoder_onehot #(
    .SEL_W      (SEL_W),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_onehot (
    .sel     (sel_n),
    .en      (on_n),
    .lines_c (out_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      out       <= {OUT_W{ACTIVE_LOW}};
      out_valid <= 1'b0;
      cur_sel   <= '0;
      scan_wrap <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      out       <= out_d;
      out_valid <= on_n;
      cur_sel   <= sel_n;
      scan_wrap <= wrap_n;
    end
  end

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// Bench for decoder_scan_nto2n: four parameterisations driven in parallel against a schedule-based model.
module tb_decoder_scan_nto2n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, mode, in_valid;
  logic [2:0] sel_in;
  logic [7:0] dwell;

  logic [7:0] out_a, out_b, out_c;
  logic [1:0] out_d;
  logic       ov_a, ov_b, ov_c, ov_d;
  logic [2:0] cs_a, cs_b, cs_c;
  logic [0:0] cs_d;
  logic       sw_a, sw_b, sw_c, sw_d;
  logic       rdy_a, rdy_b, rdy_c, rdy_d;

  always #5 clk = ~clk;

  decoder_scan_nto2n #(.SEL_W(3), .DWELL_W(8), .ACTIVE_LOW(1'b0), .BLANK_EN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .in_valid(in_valid),
    .in_ready(rdy_a), .sel_in(sel_in), .dwell(dwell), .out(out_a), .out_valid(ov_a),
    .cur_sel(cs_a), .scan_wrap(sw_a));
  decoder_scan_nto2n #(.SEL_W(3), .DWELL_W(8), .ACTIVE_LOW(1'b0), .BLANK_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .in_valid(in_valid),
    .in_ready(rdy_b), .sel_in(sel_in), .dwell(dwell), .out(out_b), .out_valid(ov_b),
    .cur_sel(cs_b), .scan_wrap(sw_b));
  decoder_scan_nto2n #(.SEL_W(3), .DWELL_W(8), .ACTIVE_LOW(1'b1), .BLANK_EN(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .in_valid(in_valid),
    .in_ready(rdy_c), .sel_in(sel_in), .dwell(dwell), .out(out_c), .out_valid(ov_c),
    .cur_sel(cs_c), .scan_wrap(sw_c));
  decoder_scan_nto2n #(.SEL_W(1), .DWELL_W(8), .ACTIVE_LOW(1'b0), .BLANK_EN(1'b1)) dut_d (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .in_valid(in_valid),
    .in_ready(rdy_d), .sel_in(sel_in[0:0]), .dwell(dwell), .out(out_d), .out_valid(ov_d),
    .cur_sel(cs_d), .scan_wrap(sw_d));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: per-instance parameters, visible line state and a queue of upcoming scan cycles.
  int unsigned m_sw [4] = '{3, 3, 3, 1};
  bit          m_bl [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit          m_al [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  bit          m_act[4];
  int          m_sel[4];
  bit          m_wrap[4];
  bit          m_scan[4];
  bit          m_first[4];
  int          m_k[4];
  int          q[4][$];

  function automatic int width_of(int i);
    return 1 << m_sw[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_act[i] = 0; m_sel[i] = 0; m_wrap[i] = 0; m_scan[i] = 0;
      m_first[i] = 0; m_k[i] = 0; q[i].delete();
    end
  endtask

  task automatic model_edge();
    int e;
    for (int i = 0; i < 4; i++) begin
      if (!enable) begin
        m_act[i] = 0; m_sel[i] = 0; m_wrap[i] = 0; m_scan[i] = 0; q[i].delete();
      end else if (!mode) begin
        m_wrap[i] = 0;
        q[i].delete();
        if (in_valid) begin
          m_act[i] = 1;
          m_sel[i] = int'(sel_in) % width_of(i);
        end else if (m_scan[i]) begin
          m_act[i] = 0;
        end
        m_scan[i] = 0;
      end else begin
        if (!m_scan[i]) begin
          m_scan[i] = 1; m_k[i] = 0; m_first[i] = 1; q[i].delete();
        end
        // A new step is scheduled (with the dwell seen now) once the previous one is used up.
        if (q[i].size() == 0) begin
          for (int j = 0; j <= int'(dwell); j++)
            q[i].push_back((1 << 16) | ((j == 0 && m_k[i] == 0 && !m_first[i]) ? (1 << 8) : 0) | m_k[i]);
          if (m_bl[i]) q[i].push_back(m_k[i]);
          m_k[i]     = (m_k[i] + 1) % width_of(i);
          m_first[i] = 0;
        end
        e         = q[i].pop_front();
        m_act[i]  = e[16];
        m_wrap[i] = e[8];
        m_sel[i]  = e & 8'hFF;
      end
    end
  endtask

  function automatic logic [63:0] exp_out(int i);
    logic [63:0] mask, v;
    mask = (width_of(i) == 64) ? '1 : ((64'd1 << width_of(i)) - 64'd1);
    v    = m_act[i] ? (64'd1 << m_sel[i]) : 64'd0;
    if (m_al[i]) v = ~v & mask;
    return v;
  endfunction

  function automatic logic [63:0] obs(int i, int f);
    logic [63:0] r;
    r = '0;
    case (i)
      0: case (f) 0: r = 64'(out_a); 1: r = 64'(ov_a); 2: r = 64'(cs_a); default: r = 64'(sw_a); endcase
      1: case (f) 0: r = 64'(out_b); 1: r = 64'(ov_b); 2: r = 64'(cs_b); default: r = 64'(sw_b); endcase
      2: case (f) 0: r = 64'(out_c); 1: r = 64'(ov_c); 2: r = 64'(cs_c); default: r = 64'(sw_c); endcase
      default: case (f) 0: r = 64'(out_d); 1: r = 64'(ov_d); 2: r = 64'(cs_d); default: r = 64'(sw_d); endcase
    endcase
    return r;
  endfunction

  task automatic compare_all();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("out%0d", i),   obs(i, 0), exp_out(i));
      check($sformatf("valid%0d", i), obs(i, 1), 64'(m_act[i]));
      check($sformatf("sel%0d", i),   obs(i, 2), 64'(m_sel[i]));
      check($sformatf("wrap%0d", i),  obs(i, 3), 64'(m_wrap[i]));
    end
    check("ready_a", 64'(rdy_a), 64'(enable & ~mode));
    check("ready_d", 64'(rdy_d), 64'(enable & ~mode));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_out_a", 64'(out_a), 64'h00);
    check("rst_out_c", 64'(out_c), 64'hFF);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; mode = 1'b0; in_valid = 1'b0; sel_in = '0; dwell = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 compare_all();
    @(negedge clk) rst_n = 1'b1;

    // Direct capture and hold.
    enable = 1'b1; in_valid = 1'b1; sel_in = 3'd5;
    tick();
    check("dir5_a", 64'(out_a), 64'h20);
    check("dir5_c", 64'(out_c), 64'hDF);
    in_valid = 1'b0; sel_in = 3'd2;
    tick();
    check("hold_a", 64'(out_a), 64'h20);

    // Scan with dwell=1, then async reset mid-scan.
    mode = 1'b1; dwell = 8'd1;
    tick();
    check("scan0_a", 64'(out_a), 64'h01);
    tick();
    check("scan1_a", 64'(out_a), 64'h01);
    tick();
    check("blank_a", 64'(out_a), 64'h00);
    repeat (30) tick();
    async_reset();

    // Dwell 0 scans: full wrap for every instance.
    dwell = 8'd0;
    repeat (40) tick();

    // Active-low direct, then disable with in_valid pulses ignored.
    mode = 1'b0; in_valid = 1'b1; sel_in = 3'd0;
    tick();
    check("al_sel0_c", 64'(out_c), 64'hFE);
    enable = 1'b0;
    tick();
    check("dis_c", 64'(out_c), 64'hFF);
    check("dis_rdy", 64'(rdy_c), 64'h0);
    sel_in = 3'd6;
    repeat (3) tick();
    in_valid = 1'b0;
    enable = 1'b1;

    // Leave scan mid-step with a same-cycle capture, then re-enter scan.
    mode = 1'b1; dwell = 8'd3;
    repeat (2) tick();
    mode = 1'b0; in_valid = 1'b1; sel_in = 3'd3;
    tick();
    check("exit_cap_a", 64'(out_a), 64'h08);
    mode = 1'b1; in_valid = 1'b0;
    tick();
    check("restart_a", 64'(out_a), 64'h01);

    // Randomised operation.
    for (int n = 0; n < 3000; n++) begin
      enable   = ($urandom % 16) != 0;
      if ($urandom % 20 == 0) mode = ~mode;
      in_valid = $urandom % 2;
      sel_in   = 3'($urandom);
      dwell    = 8'($urandom % 4);
      tick();
      if ($urandom % 250 == 0) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
